// File: rtl/m_pcpi_initiator_if.sv
// Bundles the upstream request, downstream response and PCPI bus of the M-extension initiator.
// master = initiator (CPU) side, slave = the environment around it.
interface m_pcpi_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_trap;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_busy;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;

    modport master (
        input  req_valid, req_instr, req_rs1, req_rs2, rsp_ready,
        input  pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd,
        output req_ready, rsp_valid, rsp_data, rsp_wr, rsp_trap,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );

    modport slave (
        output req_valid, req_instr, req_rs1, req_rs2, rsp_ready,
        output pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd,
        input  req_ready, rsp_valid, rsp_data, rsp_wr, rsp_trap,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );
endinterface

// File: rtl/m_pcpi_initiator.sv
// CPU-side PCPI initiator: issues one instruction, waits for the coprocessor, returns result or trap.
// Define M_PCPI_PERF_EN to add the perf_ops / perf_last_lat performance counters.
module m_pcpi_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    m_pcpi_initiator_if.master   bus
`ifdef M_PCPI_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [15:0]          perf_last_lat
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] insn_q, rs1_q, rs2_q, data_q;
    logic        wr_q, trap_q;
    logic [CW-1:0] cnt_q;
    logic        accept, capture, timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ready outranks busy, busy outranks the no-claim timeout
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.pcpi_ready) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (bus.pcpi_busy) begin
                    state_nxt = WAIT;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (bus.pcpi_ready) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insn_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            trap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                insn_q <= bus.req_instr;
                rs1_q  <= bus.req_rs1;
                rs2_q  <= bus.req_rs2;
                cnt_q  <= '0;
            end else if (state == ISSUE) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (capture) begin
                data_q <= bus.pcpi_wr ? bus.pcpi_rd : 32'd0;
                wr_q   <= bus.pcpi_wr;
                trap_q <= 1'b0;
            end else if (timeout) begin
                data_q <= 32'd0;
                wr_q   <= 1'b0;
                trap_q <= 1'b1;
            end
        end
    end

`ifdef M_PCPI_PERF_EN
    logic [15:0] lat_q;

    // lat_q counts every cycle pcpi_valid is high and is published when the response is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q         <= '0;
            perf_ops      <= '0;
            perf_last_lat <= '0;
        end else begin
            if (accept) begin
                lat_q <= '0;
            end else if ((state == ISSUE || state == WAIT) && lat_q != 16'hFFFF) begin
                lat_q <= lat_q + 16'd1;
            end
            if (state == RESP && bus.rsp_ready) begin
                perf_ops      <= perf_ops + 32'd1;
                perf_last_lat <= lat_q;
            end
        end
    end
`endif

    // req_ready is masked by reset so every output reads 0 while reset is held
    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.pcpi_valid = (state == ISSUE) || (state == WAIT);
    assign bus.pcpi_insn  = insn_q;
    assign bus.pcpi_rs1   = rs1_q;
    assign bus.pcpi_rs2   = rs2_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_wr     = wr_q;
    assign bus.rsp_trap   = trap_q;
endmodule

// File: tb/tb_m_pcpi_initiator.sv
// Self-checking bench for m_pcpi_initiator: a scripted M-extension coprocessor stub plus a
// transaction-level predictor of result, trap and pcpi_valid duration; optional perf counters checked.
module tb_m_pcpi_initiator;
    localparam int T = 16;

    logic clk;
    logic reset;
    m_pcpi_initiator_if bus ();

`ifdef M_PCPI_PERF_EN
    logic [31:0] perf_ops;
    logic [15:0] perf_last_lat;
    int          exp_ops;
`endif

    m_pcpi_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef M_PCPI_PERF_EN
        ,
        .perf_ops      (perf_ops),
        .perf_last_lat (perf_last_lat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    bit          cmp_en = 1'b0;
    bit          exp_req_ready, exp_pcpi_valid, exp_rsp_valid;
    logic [31:0] exp_insn, exp_rs1, exp_rs2, exp_data;
    bit          exp_wr, exp_trap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference M-extension arithmetic for the coprocessor stub
    function automatic logic [31:0] m_ext(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int sa, sb;
        if (instr[6:0] != 7'h33 || instr[31:25] != 7'h01) return 32'd0;
        sa = a;
        sb = b;
        case (instr[14:12])
            3'd0: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Compare process: mid-cycle check of every output against the current expectation
    always @(negedge clk) begin
        if (cmp_en) begin
            if (bus.pcpi_valid === 1'b1) vcount++;
            check("req_ready", 32'(bus.req_ready), 32'(exp_req_ready));
            check("pcpi_valid", 32'(bus.pcpi_valid), 32'(exp_pcpi_valid));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
            if (exp_pcpi_valid) begin
                check("pcpi_insn", bus.pcpi_insn, exp_insn);
                check("pcpi_rs1", bus.pcpi_rs1, exp_rs1);
                check("pcpi_rs2", bus.pcpi_rs2, exp_rs2);
            end
            if (exp_rsp_valid) begin
                check("rsp_data", bus.rsp_data, exp_data);
                check("rsp_wr", 32'(bus.rsp_wr), 32'(exp_wr));
                check("rsp_trap", 32'(bus.rsp_trap), 32'(exp_trap));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_instr  = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.rsp_ready  = 1'b0;
        bus.pcpi_busy  = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_pcpi_valid"}, 32'(bus.pcpi_valid), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_pcpi_insn"}, bus.pcpi_insn, 32'd0);
        check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        check({tag, "_rsp_trap"}, 32'(bus.rsp_trap), 32'd0);
    endtask

    // One transaction; busy_at/ready_at are 1-based pcpi_valid cycles (0 = never)
    task automatic applyStimulus(input string name, input logic [31:0] instr, input logic [31:0] a,
                                 input logic [31:0] b, input int busy_at, input int ready_at,
                                 input bit wr, input int hold, input logic [31:0] lit_data,
                                 input bit lit_trap, input int lit_lat);
        logic [31:0] rd;
        bit normal;
        int lat;
        rd     = m_ext(instr, a, b);
        normal = (ready_at != 0) &&
                 (ready_at <= T || (busy_at != 0 && busy_at <= T && busy_at < ready_at));
        lat    = normal ? ready_at : T;
        exp_data = (normal && wr) ? rd : 32'd0;
        exp_wr   = normal && wr;
        exp_trap = !normal;
        exp_insn = instr;
        exp_rs1  = a;
        exp_rs2  = b;

        bus.req_valid = 1'b1;
        bus.req_instr = instr;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        exp_req_ready = 1'b1;
        exp_pcpi_valid = 1'b0;
        exp_rsp_valid  = 1'b0;
        vcount = 0;
        step();

        for (int c = 1; c <= lat; c++) begin
            bus.req_instr  = ~instr;
            bus.req_rs1    = ~a;
            exp_req_ready  = 1'b0;
            exp_pcpi_valid = 1'b1;
            bus.pcpi_busy  = (busy_at != 0) && (c >= busy_at) && (c != ready_at);
            bus.pcpi_ready = (c == ready_at);
            bus.pcpi_wr    = wr;
            bus.pcpi_rd    = (c == ready_at) ? rd : 32'hDEADBEEF;
            step();
        end

        // Response phase: stray pcpi_ready must be ignored
        bus.pcpi_busy  = 1'b0;
        bus.pcpi_ready = 1'b1;
        bus.pcpi_rd    = 32'h12345678;
        exp_pcpi_valid = 1'b0;
        exp_rsp_valid  = 1'b1;
        checkOutput(name, lit_data, lit_trap, lit_lat);
        for (int h = 0; h <= hold; h++) begin
            bus.rsp_ready = (h == hold);
            if (h == hold) bus.req_valid = 1'b0;
            step();
        end
        bus.pcpi_ready = 1'b0;
        bus.rsp_ready  = 1'b0;
        exp_rsp_valid  = 1'b0;
        exp_req_ready  = 1'b1;
`ifdef M_PCPI_PERF_EN
        exp_ops++;
        check({name, "_perf_ops"}, perf_ops, 32'(exp_ops));
        check({name, "_perf_last_lat"}, 32'(perf_last_lat), 32'(lat));
`endif
    endtask

    task automatic checkOutput(input string name, input logic [31:0] lit_data, input bit lit_trap,
                               input int lit_lat);
        check({name, "_lit_data"}, bus.rsp_data, lit_data);
        check({name, "_lit_trap"}, 32'(bus.rsp_trap), 32'(lit_trap));
        check({name, "_lit_valid_cycles"}, 32'(vcount), 32'(lit_lat));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        exp_req_ready = 1'b0;
        exp_pcpi_valid = 1'b0;
        exp_rsp_valid = 1'b0;
`ifdef M_PCPI_PERF_EN
        exp_ops = 0;
`endif
        #1;
        check_all_zero("reset");
        cmp_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_req_ready = 1'b1;
        step();

        applyStimulus("mul", 32'h02B50533, 32'd7, 32'd6, 1, 3, 1'b1, 0, 32'd42, 1'b0, 3);
        applyStimulus("div", 32'h02B54533, 32'hFFFFFFEC, 32'd3, 1, 34, 1'b1, 0, 32'hFFFFFFFA, 1'b0, 34);
        applyStimulus("add_trap", 32'h00B50533, 32'd1, 32'd2, 0, 0, 1'b1, 0, 32'd0, 1'b1, 16);
        applyStimulus("divu0", 32'h02B55533, 32'd100, 32'd0, 0, 2, 1'b1, 3, 32'hFFFFFFFF, 1'b0, 2);
        applyStimulus("ready_at_expiry", 32'h02B50533, 32'd3, 32'hFFFFFFFE, 0, 16, 1'b1, 0, 32'hFFFFFFFA, 1'b0, 16);
        applyStimulus("busy_at_expiry", 32'h02B50533, 32'd1000, 32'd1000, 16, 20, 1'b1, 1, 32'h000F4240, 1'b0, 20);
        applyStimulus("wr0", 32'h02B50533, 32'd5, 32'd5, 0, 2, 1'b0, 0, 32'd0, 1'b0, 2);

        // Reset while a DIV sits in WAIT
        bus.req_valid = 1'b1;
        bus.req_instr = 32'h02B54533;
        bus.req_rs1   = 32'd50;
        bus.req_rs2   = 32'd7;
        exp_insn = 32'h02B54533;
        exp_rs1  = 32'd50;
        exp_rs2  = 32'd7;
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            exp_req_ready  = 1'b0;
            exp_pcpi_valid = 1'b1;
            bus.pcpi_busy  = 1'b1;
            step();
        end
        exp_pcpi_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        bus.pcpi_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_req_ready = 1'b1;
`ifdef M_PCPI_PERF_EN
        exp_ops = 0;
        check("midreset_perf_ops", perf_ops, 32'd0);
`endif
        step();

        applyStimulus("mul_after_reset", 32'h02B50533, 32'd3, 32'd5, 1, 3, 1'b1, 0, 32'd15, 1'b0, 3);
        applyStimulus("add_trap2", 32'h00B50533, 32'd9, 32'd9, 0, 0, 1'b1, 0, 32'd0, 1'b1, 16);
`ifdef M_PCPI_PERF_EN
        check("lit_perf_ops", perf_ops, 32'd2);
        check("lit_perf_last_lat", 32'(perf_last_lat), 32'd16);
`endif
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
